// File: rtl/memif_pkg.sv
// Shared defaults and types for the MEMIF fifo-side controller.
package memif_pkg;
  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 4;
  localparam int OBUF_DEPTH = 2;

  typedef logic [AWIDTH_DEF:0]   ptr_t;
  typedef logic [AWIDTH_DEF+1:0] level_t;
endpackage

// File: rtl/memif_obuf2.sv
// Two-entry ordered output buffer: push side is unconditional (the caller
// guarantees room), pop side is valid/ready.
module memif_obuf2 import memif_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        cnt
);
  logic [DWIDTH-1:0] head, tail;
  logic              pop;

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             tail <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        // Simultaneous push/pop: the new word lands behind whatever survives.
        2'b11: begin
          if (cnt == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/memif_fifo_ctrl.sv
// FIFO controller for the MEMIF fifo 0 port: pointer bookkeeping, read prefetch
// through a 1-cycle synchronous-read memory into a 2-entry output buffer.
module memif_fifo_ctrl import memif_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH+1:0] level,
  output logic [AWIDTH-1:0] f0_waddr,
  output logic [DWIDTH-1:0] f0_wdata,
  output logic              f0_write,
  output logic [AWIDTH-1:0] f0_raddr,
  input  logic [DWIDTH-1:0] f0_rdata
);
  localparam int DEPTH = 2**AWIDTH;
  localparam int PW    = AWIDTH + 1;
  localparam int LW    = AWIDTH + 2;

  logic [PW-1:0] wr_ptr, rd_ptr, mem_cnt;
  logic [LW-1:0] level_q;
  logic          rd_inflight, push, pop, rd_en, ob_valid;
  logic [1:0]    ob_cnt;
  logic [2:0]    ob_occ;

  assign mem_cnt  = wr_ptr - rd_ptr;
  assign in_ready = !rst && (mem_cnt != PW'(DEPTH));
  assign push     = in_valid && in_ready;

  assign out_valid = !rst && ob_valid;
  assign pop       = out_valid && out_ready;

  // Buffer slots still committed after this cycle's pop; a new read needs one free.
  assign ob_occ = {1'b0, ob_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_en  = !rst && (mem_cnt != '0) && (ob_occ < 3'(OBUF_DEPTH));

  assign f0_write = push;
  assign f0_waddr = wr_ptr[AWIDTH-1:0];
  assign f0_wdata = in_data;
  assign f0_raddr = rd_ptr[AWIDTH-1:0];

  assign level = rst ? '0 : level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      level_q     <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      rd_inflight <= rd_en;
      level_q     <= level_q + LW'(push) - LW'(pop);
    end
  end

  memif_obuf2 #(.DWIDTH(DWIDTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (f0_rdata),
    .out_valid (ob_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cnt       (ob_cnt)
  );
endmodule

// File: tb/tb_memif_fifo_ctrl.sv
// Scoreboard bench for memif_fifo_ctrl: a queue of accepted words is the
// reference FIFO; the monitor checks order, level, in_ready and head stability.
module tb_memif_fifo_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;
  localparam int CAP   = DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic [AW-1:0] f0_waddr, f0_raddr;
  logic [DW-1:0] f0_wdata;
  logic          f0_write;
  logic [DW-1:0] f0_rdata = '0;

  always #5 clk = ~clk;

  memif_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .f0_waddr(f0_waddr), .f0_wdata(f0_wdata), .f0_write(f0_write),
    .f0_raddr(f0_raddr), .f0_rdata(f0_rdata)
  );

  // External memory: write at the edge, registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (f0_write) mem[f0_waddr] <= f0_wdata;
    f0_rdata <= mem[f0_raddr];
  end

  int wraps = 0;
  always @(posedge clk)
    if (f0_write && f0_waddr == AW'(DEPTH-1)) wraps++;

  int n_chk = 0, n_fail = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: the FIFO contents as a queue; capacity is DEPTH+2.
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0, acc_cnt = 0, pop_cnt = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_level", 64'(level), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_f0_write", 64'(f0_write), 0);
      exp_q.delete();
      model_cnt = 0;
      held_v    = 1'b0;
    end else begin
      chk("level", 64'(level), 64'(model_cnt));
      chk("in_ready", 64'(in_ready), 64'(model_cnt != CAP));
      chk("f0_write", 64'(f0_write), 64'(in_valid && model_cnt != CAP));
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", 64'(out_data), 64'(held_d));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        model_cnt++;
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_nonempty", 0, 1);
        else chk("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
        model_cnt--;
        pop_cnt++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // One word into an empty FIFO: visible exactly 3 cycles after acceptance.
  task automatic single_push(string tag, logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk); chk({tag, "_accept"}, 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_valid"}, 64'(out_valid), 64'(k == 3));
      if (k == 3) chk({tag, "_data"}, 64'(out_data), 64'(d));
    end
    tick();
    @(negedge clk);
    chk({tag, "_level_after"}, 64'(level), 0);
    chk({tag, "_alone"}, 64'(out_valid), 0);
    tick();
  endtask

  initial begin
    int acc, popped, bubbles, w0, a0, p0;
    logic started, full_seen;

    do_reset(3);

    // Latency
    single_push("lat", 32'hA5A5_0001);

    // Fill with the consumer stalled
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      @(negedge clk); if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("fill_accepted", 64'(acc), 18);
    @(negedge clk);
    chk("fill_level", 64'(level), 18);
    chk("fill_in_ready", 64'(in_ready), 0);
    tick();

    // Drain: 0..17 on consecutive cycles
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); chk("drain_valid", 64'(out_valid), 1);
      tick();
    end
    @(negedge clk);
    chk("drain_empty_valid", 64'(out_valid), 0);
    chk("drain_level", 64'(level), 0);
    tick();

    // Streaming with wrap
    w0 = wraps; acc = 0; popped = 0; bubbles = 0; started = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = $urandom;
    for (int c = 0; c < 400 && popped < 100; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) popped++;
      else if (started) bubbles++;
      started = started | out_valid;
      tick();
      in_valid = (acc < 100);
      in_data  = $urandom;
    end
    in_valid = 1'b0;
    chk("stream_accepted", 64'(acc), 100);
    chk("stream_popped", 64'(popped), 100);
    chk("stream_bubbles", 64'(bubbles), 0);
    chk("stream_wraps_ge5", 64'((wraps - w0) >= 5), 1);

    // Backpressure: out_ready 1,0,0,1 repeating under a continuous push stream
    a0 = acc_cnt; p0 = pop_cnt; full_seen = 1'b0;
    for (int c = 0; c < 120; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid  = 1'b1;
      in_data   = $urandom;
      @(negedge clk); if (!in_ready) full_seen = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 60 && model_cnt != 0; c++) tick();
    chk("bp_full_reached", 64'(full_seen), 1);
    chk("bp_no_loss", 64'(pop_cnt - p0), 64'(acc_cnt - a0));
    chk("bp_queue_empty", 64'(exp_q.size()), 0);
    @(negedge clk); chk("bp_level", 64'(level), 0);
    tick();

    // Reset mid-operation with level=7 and a read in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin in_data = $urandom; tick(); end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk); chk("rst_pre_level", 64'(level), 7);
    tick();
    in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;   // push+pop issues a read
    tick();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    @(negedge clk); chk("mid_rst_f0_write", 64'(f0_write), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_level", 64'(level), 0);
    chk("post_rst_valid", 64'(out_valid), 0);
    chk("post_rst_f0_write", 64'(f0_write), 0);
    tick();
    single_push("rst", 32'h0000_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
